// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read-channel arbiter: field widths,
// slave address map, slave indices and the FSM state encoding.
package axi_rd_pkg;

    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int DATA_W  = 32;
    localparam int RESP_W  = 2;
    localparam int SID_W   = 8;
    localparam int NUM_M   = 2;
    localparam int NUM_S   = 3;

    typedef logic [1:0] slv_idx_t;

    localparam slv_idx_t S_ROM  = 2'd0;
    localparam slv_idx_t S_IM   = 2'd1;
    localparam slv_idx_t S_DM   = 2'd2;
    localparam slv_idx_t S_NONE = 2'd3;

    localparam logic [ADDR_W-1:0] ROM_BASE = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] ROM_MASK = 32'hFFFF_C000;
    localparam logic [ADDR_W-1:0] IM_BASE  = 32'h0001_0000;
    localparam logic [ADDR_W-1:0] IM_MASK  = 32'hFFFF_0000;
    localparam logic [ADDR_W-1:0] DM_BASE  = 32'h0002_0000;
    localparam logic [ADDR_W-1:0] DM_MASK  = 32'hFFFF_0000;

    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DECERR
    } rd_state_e;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } ar_req_t;

    function automatic logic addr_hit(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] mask);
        return (a & mask) == base;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Read-channel bundles: axi_rd_mst_if faces the two upstream masters,
// axi_rd_slv_if faces the three downstream slaves.
interface axi_rd_mst_if;
    import axi_rd_pkg::*;

    logic [NUM_M-1:0][ID_W-1:0]    M_ARID;
    logic [NUM_M-1:0][ADDR_W-1:0]  M_ARADDR;
    logic [NUM_M-1:0][LEN_W-1:0]   M_ARLEN;
    logic [NUM_M-1:0][SIZE_W-1:0]  M_ARSIZE;
    logic [NUM_M-1:0][BURST_W-1:0] M_ARBURST;
    logic [NUM_M-1:0]              M_ARVALID;
    logic [NUM_M-1:0]              M_ARREADY;
    logic [NUM_M-1:0][ID_W-1:0]    M_RID;
    logic [NUM_M-1:0][DATA_W-1:0]  M_RDATA;
    logic [NUM_M-1:0][RESP_W-1:0]  M_RRESP;
    logic [NUM_M-1:0]              M_RLAST;
    logic [NUM_M-1:0]              M_RVALID;
    logic [NUM_M-1:0]              M_RREADY;

    modport master (
        output M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID, M_RREADY,
        input  M_ARREADY, M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID
    );
    modport slave (
        input  M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID, M_RREADY,
        output M_ARREADY, M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID
    );
endinterface

interface axi_rd_slv_if;
    import axi_rd_pkg::*;

    logic [NUM_S-1:0][SID_W-1:0]   S_ARID;
    logic [NUM_S-1:0][ADDR_W-1:0]  S_ARADDR;
    logic [NUM_S-1:0][LEN_W-1:0]   S_ARLEN;
    logic [NUM_S-1:0][SIZE_W-1:0]  S_ARSIZE;
    logic [NUM_S-1:0][BURST_W-1:0] S_ARBURST;
    logic [NUM_S-1:0]              S_ARVALID;
    logic [NUM_S-1:0]              S_ARREADY;
    logic [NUM_S-1:0][SID_W-1:0]   S_RID;
    logic [NUM_S-1:0][DATA_W-1:0]  S_RDATA;
    logic [NUM_S-1:0][RESP_W-1:0]  S_RRESP;
    logic [NUM_S-1:0]              S_RLAST;
    logic [NUM_S-1:0]              S_RVALID;
    logic [NUM_S-1:0]              S_RREADY;

    modport master (
        output S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY,
        input  S_ARREADY, S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID
    );
    modport slave (
        input  S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY,
        output S_ARREADY, S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID
    );
endinterface

// File: rtl/axi_rd_decoder.sv
// Address decoder: maps a read address onto ROM / IM / DM, or S_NONE when
// the address falls outside every window.
module axi_rd_decoder
    import axi_rd_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output slv_idx_t          slv
);

    always_comb begin
        slv = S_NONE;
        if (addr_hit(addr, ROM_BASE, ROM_MASK)) begin
            slv = S_ROM;
        end else if (addr_hit(addr, IM_BASE, IM_MASK)) begin
            slv = S_IM;
        end else if (addr_hit(addr, DM_BASE, DM_MASK)) begin
            slv = S_DM;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master / three-slave AXI read arbiter with a single outstanding burst
// and local DECERR generation. Define AXI_RD_RR_ARB_EN for round-robin grants.
module axi_rd_arbiter
    import axi_rd_pkg::*;
(
    input  logic               ACLK,
    input  logic               ARESETn,
    axi_rd_mst_if.slave        m,
    axi_rd_slv_if.master       s,
    output logic [1:0]         select
);

    rd_state_e   state_q, state_d;
    ar_req_t     ar_q, ar_d;
    logic        g_q, g_d;
    slv_idx_t    slv_q, slv_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  select_q, select_d;

    logic        gnt;
    logic        ar_req;
    ar_req_t     ar_in;
    slv_idx_t    dec_slv;

    // Response side of the currently selected slave / granted master.
    logic                 r_vld, r_last, ar_rdy, m_rready_g;
    logic [SID_W-1:0]     r_id;
    logic [DATA_W-1:0]    r_data;
    logic [RESP_W-1:0]    r_resp;
    logic                 unused_rid;

    assign ar_req = |m.M_ARVALID;

`ifdef AXI_RD_RR_ARB_EN
    logic last_q, last_d;

    always_comb begin
        if (m.M_ARVALID == 2'b11) gnt = ~last_q;
        else                      gnt = m.M_ARVALID[1];
    end
`else
    assign gnt = ~m.M_ARVALID[0] & m.M_ARVALID[1];
`endif

    always_comb begin
        ar_in       = '0;
        ar_in.id    = m.M_ARID[gnt];
        ar_in.addr  = m.M_ARADDR[gnt];
        ar_in.len   = m.M_ARLEN[gnt];
        ar_in.size  = m.M_ARSIZE[gnt];
        ar_in.burst = m.M_ARBURST[gnt];
    end

    axi_rd_decoder u_dec (
        .addr (ar_in.addr),
        .slv  (dec_slv)
    );

    always_comb begin
        r_vld  = 1'b0;
        r_last = 1'b0;
        ar_rdy = 1'b0;
        r_id   = '0;
        r_data = '0;
        r_resp = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (slv_q == slv_idx_t'(i)) begin
                r_vld  = s.S_RVALID[i];
                r_last = s.S_RLAST[i];
                ar_rdy = s.S_ARREADY[i];
                r_id   = s.S_RID[i];
                r_data = s.S_RDATA[i];
                r_resp = s.S_RRESP[i];
            end
        end
        m_rready_g = m.M_RREADY[g_q];
    end

    // Master RID is only 4 bits; the upper nibble carries the master tag.
    assign unused_rid = ^r_id[SID_W-1:ID_W];

    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        g_d      = g_q;
        slv_d    = slv_q;
        cnt_d    = cnt_q;
        select_d = select_q;
`ifdef AXI_RD_RR_ARB_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (ar_req) begin
                    ar_d     = ar_in;
                    g_d      = gnt;
                    slv_d    = dec_slv;
                    select_d = gnt ? 2'd2 : 2'd1;
`ifdef AXI_RD_RR_ARB_EN
                    last_d   = gnt;
`endif
                    if (dec_slv == S_NONE) begin
                        state_d = DECERR;
                        cnt_d   = {1'b0, ar_in.len} + 5'd1;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (ar_rdy) state_d = DATA;
            end
            DATA: begin
                if (r_vld && m_rready_g && r_last) begin
                    state_d  = IDLE;
                    select_d = 2'd0;
                end
            end
            DECERR: begin
                if (m_rready_g) begin
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d  = IDLE;
                        select_d = 2'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            ar_q     <= '0;
            g_q      <= 1'b0;
            slv_q    <= S_ROM;
            cnt_q    <= '0;
            select_q <= 2'd0;
`ifdef AXI_RD_RR_ARB_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            ar_q     <= ar_d;
            g_q      <= g_d;
            slv_q    <= slv_d;
            cnt_q    <= cnt_d;
            select_q <= select_d;
`ifdef AXI_RD_RR_ARB_EN
            last_q   <= last_d;
`endif
        end
    end

    always_comb begin
        m.M_ARREADY = '0;
        m.M_RID     = '0;
        m.M_RDATA   = '0;
        m.M_RRESP   = '0;
        m.M_RLAST   = '0;
        m.M_RVALID  = '0;
        s.S_ARID    = '0;
        s.S_ARADDR  = '0;
        s.S_ARLEN   = '0;
        s.S_ARSIZE  = '0;
        s.S_ARBURST = '0;
        s.S_ARVALID = '0;
        s.S_RREADY  = '0;
        case (state_q)
            IDLE: begin
                // Gated by reset so no handshake can be offered while held in reset.
                if (ARESETn && ar_req) m.M_ARREADY[gnt] = 1'b1;
            end
            ADDR: begin
                for (int i = 0; i < NUM_S; i++) begin
                    if (slv_q == slv_idx_t'(i)) begin
                        s.S_ARVALID[i] = 1'b1;
                        s.S_ARID[i]    = {3'b000, g_q, ar_q.id};
                        s.S_ARADDR[i]  = ar_q.addr;
                        s.S_ARLEN[i]   = ar_q.len;
                        s.S_ARSIZE[i]  = ar_q.size;
                        s.S_ARBURST[i] = ar_q.burst;
                    end
                end
            end
            DATA: begin
                m.M_RVALID[g_q] = r_vld;
                m.M_RLAST[g_q]  = r_last;
                m.M_RID[g_q]    = r_id[ID_W-1:0];
                m.M_RDATA[g_q]  = r_data;
                m.M_RRESP[g_q]  = r_resp;
                for (int i = 0; i < NUM_S; i++) begin
                    if (slv_q == slv_idx_t'(i)) s.S_RREADY[i] = m_rready_g;
                end
            end
            DECERR: begin
                m.M_RVALID[g_q] = 1'b1;
                m.M_RLAST[g_q]  = (cnt_q == 5'd1);
                m.M_RID[g_q]    = ar_q.id;
                m.M_RRESP[g_q]  = RESP_DECERR;
            end
            default: ;
        endcase
    end

    assign select = select_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter; expectations follow AXI_RD_RR_ARB_EN when defined.
module tb_axi_rd_arbiter;
    import axi_rd_pkg::*;

    logic       ACLK = 1'b0;
    logic       ARESETn = 1'b0;
    logic [1:0] select;
    int         n_chk = 0;
    int         n_fail = 0;
    logic       rr;

    axi_rd_mst_if mif();
    axi_rd_slv_if sif();

    axi_rd_arbiter dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .m       (mif),
        .s       (sif),
        .select  (select)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clr_inputs();
        mif.M_ARID = '0; mif.M_ARADDR = '0; mif.M_ARLEN = '0; mif.M_ARSIZE = '0;
        mif.M_ARBURST = '0; mif.M_ARVALID = '0; mif.M_RREADY = '0;
        sif.S_ARREADY = '0; sif.S_RID = '0; sif.S_RDATA = '0; sif.S_RRESP = '0;
        sif.S_RLAST = '0; sif.S_RVALID = '0;
    endtask

    task automatic test_reset();
        clr_inputs();
        ARESETn = 1'b0;
        mif.M_ARVALID = 2'b11;
        tick(); tick(); #1;
        n_chk++; if (mif.M_ARREADY !== 2'b00) begin n_fail++; $display("FAIL rst_arready: got %b exp 00", mif.M_ARREADY); end
        n_chk++; if ({mif.M_RVALID, mif.M_RLAST, mif.M_RID, mif.M_RDATA, mif.M_RRESP} !== '0) begin n_fail++; $display("FAIL rst_mr: got %b/%b exp 0", mif.M_RVALID, mif.M_RLAST); end
        n_chk++; if ({sif.S_ARVALID, sif.S_RREADY, sif.S_ARID, sif.S_ARADDR, sif.S_ARLEN} !== '0) begin n_fail++; $display("FAIL rst_sar: got %b/%b exp 0", sif.S_ARVALID, sif.S_RREADY); end
        n_chk++; if (select !== 2'd0) begin n_fail++; $display("FAIL rst_select: got %0d exp 0", select); end
        mif.M_ARVALID = 2'b00;
        ARESETn = 1'b1;
        tick();
    endtask

    task automatic test_arb();
        mif.M_ARVALID = 2'b11;
        mif.M_ARID[0] = 4'h2; mif.M_ARADDR[0] = 32'h0001_0000;
        mif.M_ARID[1] = 4'h7; mif.M_ARADDR[1] = 32'h0001_0040;
        #1;
        n_chk++; if (mif.M_ARREADY !== 2'b01) begin n_fail++; $display("FAIL arb_first: got %b exp 01", mif.M_ARREADY); end
        tick();
        n_chk++; if (sif.S_ARVALID !== 3'b010 || sif.S_ARID[1] !== 8'h02) begin n_fail++; $display("FAIL arb_sar1: got %b/%h exp 010/02", sif.S_ARVALID, sif.S_ARID[1]); end
        n_chk++; if (select !== 2'd1 || mif.M_ARREADY !== 2'b00) begin n_fail++; $display("FAIL arb_sel1: got %0d/%b exp 1/00", select, mif.M_ARREADY); end
        sif.S_ARREADY = 3'b010;
        tick();
        sif.S_ARREADY = 3'b000;
        sif.S_RVALID = 3'b010; sif.S_RLAST = 3'b010; sif.S_RID[1] = 8'h02; sif.S_RDATA[1] = 32'h1111_1111;
        mif.M_RREADY = 2'b11;
        #1;
        n_chk++; if (mif.M_RVALID !== 2'b01 || mif.M_RDATA[0] !== 32'h1111_1111) begin n_fail++; $display("FAIL arb_r1: got %b/%h exp 01/11111111", mif.M_RVALID, mif.M_RDATA[0]); end
        n_chk++; if (mif.M_ARREADY !== 2'b00) begin n_fail++; $display("FAIL arb_rlast_stall: got %b exp 00", mif.M_ARREADY); end
        tick();
        sif.S_RVALID = '0; sif.S_RLAST = '0; mif.M_RREADY = '0;
        #1;
        n_chk++; if (mif.M_ARREADY !== (rr ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL arb_second: got %b exp %b", mif.M_ARREADY, rr ? 2'b10 : 2'b01); end
        n_chk++; if (select !== 2'd0) begin n_fail++; $display("FAIL arb_sel_idle: got %0d exp 0", select); end
        tick();
        mif.M_ARVALID = 2'b00;
        #1;
        n_chk++; if (select !== (rr ? 2'd2 : 2'd1) || sif.S_ARID[1] !== (rr ? 8'h17 : 8'h02)) begin n_fail++; $display("FAIL arb_sar2: got %0d/%h exp %0d/%h", select, sif.S_ARID[1], rr ? 2 : 1, rr ? 8'h17 : 8'h02); end
        sif.S_ARREADY = 3'b010;
        tick();
        sif.S_ARREADY = 3'b000;
        sif.S_RVALID = 3'b010; sif.S_RLAST = 3'b010; sif.S_RID[1] = rr ? 8'h17 : 8'h02; sif.S_RDATA[1] = 32'h2222_2222;
        mif.M_RREADY = 2'b11;
        #1;
        n_chk++; if (mif.M_RVALID !== (rr ? 2'b10 : 2'b01) || mif.M_RID !== (rr ? 8'h70 : 8'h02)) begin n_fail++; $display("FAIL arb_r2: got %b/%h exp %b/%h", mif.M_RVALID, mif.M_RID, rr ? 2'b10 : 2'b01, rr ? 8'h70 : 8'h02); end
        tick();
        clr_inputs();
    endtask

    task automatic test_rom_single();
        mif.M_ARVALID = 2'b01; mif.M_ARID[0] = 4'h5; mif.M_ARADDR[0] = 32'h0000_0010;
        mif.M_ARLEN[0] = 4'd0; mif.M_ARSIZE[0] = 3'd2; mif.M_ARBURST[0] = 2'd1;
        #1;
        n_chk++; if (mif.M_ARREADY !== 2'b01) begin n_fail++; $display("FAIL rom_arready: got %b exp 01", mif.M_ARREADY); end
        tick();
        mif.M_ARVALID = 2'b00;
        #1;
        n_chk++; if (sif.S_ARVALID !== 3'b001 || sif.S_ARID[0] !== 8'h05) begin n_fail++; $display("FAIL rom_sar: got %b/%h exp 001/05", sif.S_ARVALID, sif.S_ARID[0]); end
        n_chk++; if (sif.S_ARADDR[0] !== 32'h10 || sif.S_ARSIZE[0] !== 3'd2 || sif.S_ARBURST[0] !== 2'd1) begin n_fail++; $display("FAIL rom_fields: got %h/%0d/%0d exp 10/2/1", sif.S_ARADDR[0], sif.S_ARSIZE[0], sif.S_ARBURST[0]); end
        n_chk++; if (select !== 2'd1) begin n_fail++; $display("FAIL rom_select: got %0d exp 1", select); end
        tick();
        n_chk++; if (sif.S_ARVALID !== 3'b001) begin n_fail++; $display("FAIL rom_hold: got %b exp 001", sif.S_ARVALID); end
        sif.S_ARREADY = 3'b001;
        tick();
        sif.S_ARREADY = 3'b000;
        sif.S_RVALID = 3'b001; sif.S_RLAST = 3'b001; sif.S_RID[0] = 8'h05; sif.S_RDATA[0] = 32'hDEAD_BEEF;
        mif.M_RREADY = 2'b01;
        #1;
        n_chk++; if (sif.S_ARVALID !== 3'b000) begin n_fail++; $display("FAIL rom_sar_drop: got %b exp 000", sif.S_ARVALID); end
        n_chk++; if (mif.M_RVALID !== 2'b01 || mif.M_RDATA[0] !== 32'hDEAD_BEEF || mif.M_RLAST !== 2'b01) begin n_fail++; $display("FAIL rom_r: got %b/%h/%b exp 01/deadbeef/01", mif.M_RVALID, mif.M_RDATA[0], mif.M_RLAST); end
        n_chk++; if (mif.M_RID[0] !== 4'h5 || sif.S_RREADY !== 3'b001) begin n_fail++; $display("FAIL rom_rid: got %h/%b exp 5/001", mif.M_RID[0], sif.S_RREADY); end
        tick();
        clr_inputs();
        #1;
        n_chk++; if (select !== 2'd0 || mif.M_RVALID !== 2'b00) begin n_fail++; $display("FAIL rom_idle: got %0d/%b exp 0/00", select, mif.M_RVALID); end
    endtask

    task automatic test_dm_burst();
        logic v_tab [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic r_tab [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int beat = 0;
        tick();
        mif.M_ARVALID = 2'b10; mif.M_ARID[1] = 4'hA; mif.M_ARADDR[1] = 32'h0002_0000; mif.M_ARLEN[1] = 4'd3;
        #1;
        n_chk++; if (mif.M_ARREADY !== 2'b10) begin n_fail++; $display("FAIL dm_arready: got %b exp 10", mif.M_ARREADY); end
        tick();
        mif.M_ARVALID = 2'b00;
        #1;
        n_chk++; if (sif.S_ARVALID !== 3'b100 || sif.S_ARID[2] !== 8'h1A || sif.S_ARLEN[2] !== 4'd3 || select !== 2'd2) begin n_fail++; $display("FAIL dm_sar: got %b/%h/%0d/%0d exp 100/1a/3/2", sif.S_ARVALID, sif.S_ARID[2], sif.S_ARLEN[2], select); end
        sif.S_ARREADY = 3'b100;
        tick();
        sif.S_ARREADY = 3'b000;
        for (int c = 0; c < 7; c++) begin
            sif.S_RVALID[2] = v_tab[c];
            sif.S_RDATA[2]  = 32'h3000 + 32'(beat);
            sif.S_RLAST[2]  = v_tab[c] && (beat == 3);
            mif.M_RREADY[1] = r_tab[c];
            #1;
            n_chk++; if (mif.M_RVALID !== {v_tab[c], 1'b0}) begin n_fail++; $display("FAIL dm_rvalid c%0d: got %b exp %b", c, mif.M_RVALID, {v_tab[c], 1'b0}); end
            n_chk++; if (sif.S_RREADY !== {r_tab[c], 2'b00}) begin n_fail++; $display("FAIL dm_rready c%0d: got %b exp %b", c, sif.S_RREADY, {r_tab[c], 2'b00}); end
            if (v_tab[c]) begin
                n_chk++; if (mif.M_RDATA[1] !== 32'h3000 + 32'(beat) || mif.M_RLAST[1] !== (beat == 3)) begin n_fail++; $display("FAIL dm_beat%0d: got %h/%b exp %h/%b", beat, mif.M_RDATA[1], mif.M_RLAST[1], 32'h3000 + 32'(beat), beat == 3); end
                if (r_tab[c]) beat++;
            end
            tick();
        end
        clr_inputs();
        #1;
        n_chk++; if (select !== 2'd0 || sif.S_RREADY !== 3'b000) begin n_fail++; $display("FAIL dm_idle: got %0d/%b exp 0/000", select, sif.S_RREADY); end
    endtask

    task automatic test_decerr();
        logic rdy_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int rem = 3;
        tick();
        mif.M_ARVALID = 2'b10; mif.M_ARID[1] = 4'h3; mif.M_ARADDR[1] = 32'h1000_0000; mif.M_ARLEN[1] = 4'd2;
        #1;
        n_chk++; if (mif.M_ARREADY !== 2'b10) begin n_fail++; $display("FAIL de_arready: got %b exp 10", mif.M_ARREADY); end
        tick();
        mif.M_ARVALID = 2'b00;
        for (int c = 0; c < 4; c++) begin
            mif.M_RREADY[1] = rdy_tab[c];
            #1;
            n_chk++; if (mif.M_RVALID !== 2'b10 || mif.M_RRESP[1] !== 2'b11 || mif.M_RDATA[1] !== 32'h0 || mif.M_RID[1] !== 4'h3) begin n_fail++; $display("FAIL de_beat c%0d: got %b/%b/%h/%h exp 10/11/0/3", c, mif.M_RVALID, mif.M_RRESP[1], mif.M_RDATA[1], mif.M_RID[1]); end
            n_chk++; if (mif.M_RLAST[1] !== (rem == 1) || sif.S_ARVALID !== 3'b000 || select !== 2'd2) begin n_fail++; $display("FAIL de_last c%0d: got %b/%b/%0d exp %b/000/2", c, mif.M_RLAST[1], sif.S_ARVALID, select, rem == 1); end
            if (rdy_tab[c]) rem--;
            tick();
        end
        clr_inputs();
        #1;
        n_chk++; if (mif.M_RVALID !== 2'b00 || select !== 2'd0) begin n_fail++; $display("FAIL de_idle: got %b/%0d exp 00/0", mif.M_RVALID, select); end
    endtask

    task automatic test_decode_bounds();
        logic [31:0] a_tab [6] = '{32'h0000_3FFC, 32'h0000_4000, 32'h0000_FFFC, 32'h0001_FFFC, 32'h0002_FFFC, 32'h0003_0000};
        logic [2:0]  v_tab [6] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b100, 3'b000};
        logic [31:0] d_tab [6] = '{32'hC0DE_0000, 32'h0, 32'h0, 32'hC0DE_0001, 32'hC0DE_0002, 32'h0};
        for (int i = 0; i < 6; i++) begin
            tick();
            mif.M_ARVALID = 2'b01; mif.M_ARADDR[0] = a_tab[i]; mif.M_ARLEN[0] = 4'd0;
            tick();
            mif.M_ARVALID = 2'b00;
            #1;
            n_chk++; if (sif.S_ARVALID !== v_tab[i]) begin n_fail++; $display("FAIL dec_%h: got %b exp %b", a_tab[i], sif.S_ARVALID, v_tab[i]); end
            if (v_tab[i] == 3'b000) begin
                n_chk++; if (mif.M_RRESP[0] !== 2'b11 || mif.M_RLAST[0] !== 1'b1) begin n_fail++; $display("FAIL dec_err_%h: got %b/%b exp 11/1", a_tab[i], mif.M_RRESP[0], mif.M_RLAST[0]); end
                mif.M_RREADY = 2'b01;
                tick();
            end else begin
                sif.S_ARREADY = v_tab[i];
                tick();
                sif.S_ARREADY = '0;
                for (int k = 0; k < NUM_S; k++) sif.S_RDATA[k] = 32'hC0DE_0000 + 32'(k);
                sif.S_RVALID = v_tab[i]; sif.S_RLAST = v_tab[i]; mif.M_RREADY = 2'b01;
                #1;
                n_chk++; if (mif.M_RVALID !== 2'b01 || mif.M_RDATA[0] !== d_tab[i]) begin n_fail++; $display("FAIL dec_r_%h: got %b/%h exp 01/%h", a_tab[i], mif.M_RVALID, mif.M_RDATA[0], d_tab[i]); end
                tick();
            end
            clr_inputs();
        end
    endtask

    task automatic test_reset_mid_burst();
        tick();
        mif.M_ARVALID = 2'b01; mif.M_ARID[0] = 4'h9; mif.M_ARADDR[0] = 32'h0000_0100; mif.M_ARLEN[0] = 4'd3;
        tick();
        mif.M_ARVALID = 2'b00; sif.S_ARREADY = 3'b001;
        tick();
        sif.S_ARREADY = 3'b000;
        sif.S_RVALID = 3'b001; sif.S_RDATA[0] = 32'hAAAA_AAAA; mif.M_RREADY = 2'b01;
        #1;
        n_chk++; if (mif.M_RVALID !== 2'b01) begin n_fail++; $display("FAIL mid_rvalid: got %b exp 01", mif.M_RVALID); end
        tick();
        ARESETn = 1'b0;
        tick();
        n_chk++; if (mif.M_RVALID !== 2'b00 || mif.M_RDATA !== '0 || sif.S_RREADY !== 3'b000 || select !== 2'd0) begin n_fail++; $display("FAIL mid_rst: got %b/%h/%b/%0d exp 00/0/000/0", mif.M_RVALID, mif.M_RDATA, sif.S_RREADY, select); end
        ARESETn = 1'b1;
        clr_inputs();
        mif.M_ARVALID = 2'b01; mif.M_ARID[0] = 4'h4; mif.M_ARADDR[0] = 32'h0000_0020;
        #1;
        n_chk++; if (mif.M_ARREADY !== 2'b01) begin n_fail++; $display("FAIL post_arready: got %b exp 01", mif.M_ARREADY); end
        tick();
        mif.M_ARVALID = 2'b00;
        #1;
        n_chk++; if (sif.S_ARVALID !== 3'b001 || sif.S_ARID[0] !== 8'h04 || sif.S_ARADDR[0] !== 32'h20 || select !== 2'd1) begin n_fail++; $display("FAIL post_sar: got %b/%h/%h/%0d exp 001/04/20/1", sif.S_ARVALID, sif.S_ARID[0], sif.S_ARADDR[0], select); end
        sif.S_ARREADY = 3'b001;
        tick();
        sif.S_ARREADY = 3'b000;
        sif.S_RVALID = 3'b001; sif.S_RLAST = 3'b001; sif.S_RDATA[0] = 32'h5555_5555; mif.M_RREADY = 2'b01;
        #1;
        n_chk++; if (mif.M_RDATA[0] !== 32'h5555_5555 || mif.M_RLAST !== 2'b01) begin n_fail++; $display("FAIL post_r: got %h/%b exp 55555555/01", mif.M_RDATA[0], mif.M_RLAST); end
        tick();
        clr_inputs();
        #1;
        n_chk++; if (select !== 2'd0) begin n_fail++; $display("FAIL post_idle: got %0d exp 0", select); end
    endtask

    initial begin
`ifdef AXI_RD_RR_ARB_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        test_reset();
        test_arb();
        test_rom_single();
        test_dm_burst();
        test_decerr();
        test_decode_bounds();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Read-channel half of the system AXI interconnect: it accepts AR requests from two masters (M0 instruction fetch, M1 data), arbitrates, decodes the address, and forwards the request to one of three read slaves (S0 ROM, S1 IM SRAM, S2 DM SRAM). It then routes the R beats back to the granted master. It sits directly upstream of each slave read port and drives that slave's AR inputs, R ready, and `select` qualifier. It supports one outstanding burst and generates DECERR responses for unmapped addresses.

## Interface
- No parameters; widths come from `AXI_define.svh` (ID 4, ADDR 32, LEN 4, SIZE 3, DATA 32) and slave ID width 8.
- ACLK  in  1  clock
- ARESETn  in  1  reset: synchronous, active-low
- M_ARID/M_ARADDR/M_ARLEN/M_ARSIZE/M_ARBURST  in  [2][4]/[2][32]/[2][4]/[2][3]/[2][2]  per-master AR fields
- M_ARVALID  in  [2]  per-master request
- M_ARREADY  out  [2]  per-master accept
- M_RID/M_RDATA/M_RRESP/M_RLAST/M_RVALID  out  [2][4]/[2][32]/[2][2]/[2]/[2]  per-master R
- M_RREADY  in  [2]  per-master R ready
- S_ARID/S_ARADDR/S_ARLEN/S_ARSIZE/S_ARBURST  out  [3][8]/[3][32]/[3][4]/[3][3]/[3][2]  per-slave AR
- S_ARVALID  out  [3]  slave request
- S_ARREADY  in  [3]  slave accept
- S_RID/S_RDATA/S_RRESP/S_RLAST/S_RVALID  in  [3][8]/[3][32]/[3][2]/[3]/[3]  per-slave R
- S_RREADY  out  [3]  slave R ready
- select  out  2  granted master index + 1 (0 = none, 1 = M0, 2 = M1, 3 = reserved/never driven)

## Operation
- States: IDLE, ADDR, DATA, DECERR.
- IDLE: M_ARREADY[g] = 1 only for the master g selected this cycle by the arbiter. On the M_ARVALID[g] handshake, register the AR fields, g, and the decoded slave.
  - Mapped address -> ADDR.
  - Unmapped address -> DECERR, with beat counter = ARLEN+1.
- Decode (registered ARADDR):
  - 0x0000_0000–0x0000_3FFF -> S0.
  - 0x0001_0000–0x0001_FFFF -> S1.
  - 0x0002_0000–0x0002_FFFF -> S2.
  - Anything else -> DECERR.
- ADDR: S_ARVALID[s] = 1 with the registered fields and S_ARID = {4'(g), ARID}. On S_ARREADY[s] -> DATA.
- DATA: R channel is combinationally connected between slave s and master g.
  - M_RID = S_RID[3:0].
  - M_RREADY[g] drives S_RREADY[s].
  - All other R/ready outputs are 0.
  - On a beat with valid, ready and RLAST -> IDLE.
- DECERR: M_RVALID[g] = 1, RDATA = 0, RRESP = 2'b11, RID = registered ID, RLAST = 1 when counter == 1. The counter decrements on each handshake; the final handshake -> IDLE.
- Arbitration (with the macro enabled): round-robin.
  - If both masters request, the master not granted last wins.
  - `last` resets to M1, so M0 wins first.
  - A single requester always wins.
- Only one burst is in flight; requests made during ADDR/DATA/DECERR stall (M_ARREADY = 0).

## Timing
- Reset (ARESETn = 0 at a clock edge): state IDLE and all registers cleared. Every valid/ready/RLAST output is 0, all data/ID/resp outputs are 0, and `select` = 0.
- Reset asserted mid-burst aborts the burst; slaves share the reset.
- `select` is registered: it is nonzero from the cycle after the AR grant until the cycle after the final R handshake.
- AR latency: master handshake in cycle n -> S_ARVALID asserted in cycle n+1. It is held until S_ARREADY.
- R path: zero added latency (combinational pass-through), with no R buffering.
- DECERR beats are presented back-to-back, gated only by M_RREADY.
- RLAST handshake and a new M_ARVALID in the same cycle: the new request is not accepted that cycle (state still DATA). It is accepted in IDLE one cycle later.
- ARLEN = 15 gives 16 beats; the counter is 5 bits, so there is no wrap.

## Configuration
- `AXI_RD_RR_ARB_EN` defined: round-robin arbitration as above.
- Undefined: fixed priority; M0 always wins simultaneous requests, and the `last` register is not instantiated.

## Structure
- Package `axi_rd_pkg`:
  - Slave address-map base/mask constants.
  - Slave index constants (S_ROM = 0, S_IM = 1, S_DM = 2, S_NONE = 3).
  - State enum `rd_state_e`.
  - Slave ID width constant = 8.
- Sub-module `axi_rd_decoder`: pure combinational address -> slave index, including S_NONE.

## Test plan
- M0 ARADDR 0x0000_0010, ARLEN 0, ROM returns 0xDEAD_BEEF -> S_ARID[0] = 0x0_ID, select = 1, M_RDATA[0] = 0xDEAD_BEEF, RLAST = 1, back in IDLE.
- M0 and M1 both request in the same cycle, twice back-to-back -> grants M0 then M1 (macro on); M0, M0 when M1 is re-requesting (macro off).
- M1 ARADDR 0x0002_0000, ARLEN 3, slave deasserts RVALID between beats and M1 drops RREADY on beat 2 -> four beats delivered in order, RLAST only on the 4th.
- M1 ARADDR 0x1000_0000, ARLEN 2 -> no S_ARVALID; three beats with RRESP = 2'b11, RDATA = 0, RLAST on the 3rd.
- ARESETn low during DATA of a 4-beat burst -> next cycle all outputs 0, select = 0, IDLE; a new M0 request is then served normally.
